// File: rtl/ram_bus_arbiter_pkg.sv
// Shared types and helpers for the two-master RAM bus arbiter.
// The window test is done one bit wider than the address so a window ending at 256 does not wrap.
package ram_bus_pkg;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ADDR,
        RD_DATA,
        RD_ACK,
        ERR
    } state_t;

    function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                       input logic [ADDR_W-1:0] base,
                                       input int unsigned       width);
        logic [ADDR_W:0] lo;
        logic [ADDR_W:0] hi;
        logic [ADDR_W:0] a;
        lo = {1'b0, base};
        hi = lo + ((ADDR_W+1)'(1) << width);
        a  = {1'b0, addr};
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/ram_bus_arbiter_rr.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the
// requester that was not granted last.
module rr_arbiter_2
    import ram_bus_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last_grant,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Schedules single-byte reads/writes from two requesters onto the shared RAM bus.
// Handshake: a requester holds REQ with WE/ADDR/WDATA stable; it owns the bus while GNT is high and is done on its one-cycle ACK.
module ram_bus_arbiter
    import ram_bus_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RAMBaseAddr  = 8'h00,
    parameter int                RAMAddrWidth = 7
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NUM_REQ-1:0] REQ,
    input  logic [NUM_REQ-1:0] WE,
    input  logic [ADDR_W-1:0]  ADDR0,
    input  logic [ADDR_W-1:0]  ADDR1,
    input  logic [DATA_W-1:0]  WDATA0,
    input  logic [DATA_W-1:0]  WDATA1,
    output logic [NUM_REQ-1:0] GNT,
    output logic [NUM_REQ-1:0] ACK,
    output logic [DATA_W-1:0]  RDATA,
    output logic [ADDR_W-1:0]  BUS_ADDR,
    inout  wire  [DATA_W-1:0]  BUS_DATA,
    output logic               BUS_WE,
    output state_t             DBG_STATE
);

    state_t              state;
    logic                last_grant;
    logic [DATA_W-1:0]   wdata_q;
    logic [NUM_REQ-1:0]  grant;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_we;
    logic                sel_hit;

    rr_arbiter_2 u_rr (
        .req        (REQ),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_comb begin
        sel_addr  = grant[1] ? ADDR1  : ADDR0;
        sel_wdata = grant[1] ? WDATA1 : WDATA0;
        sel_we    = grant[1] ? WE[1]  : WE[0];
        sel_hit   = in_window(sel_addr, RAMBaseAddr, RAMAddrWidth);
    end

    // Only the WR state drives the bus; BUS_WE is registered alongside state, so the two always agree.
    assign BUS_DATA  = (state == WR) ? wdata_q : 'z;
    assign DBG_STATE = state;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            GNT        <= '0;
            ACK        <= '0;
            RDATA      <= '0;
            BUS_ADDR   <= '0;
            BUS_WE     <= 1'b0;
            wdata_q    <= '0;
            last_grant <= 1'b1;
        end else begin
            ACK <= '0;
            unique case (state)
                IDLE: begin
                    if (|REQ) begin
                        GNT        <= grant;
                        last_grant <= grant[1];
                        wdata_q    <= sel_wdata;
                        if (!sel_hit) begin
                            state <= ERR;
                            ACK   <= grant;
                            if (!sel_we) begin
                                RDATA <= '0;
                            end
                        end else begin
                            BUS_ADDR <= sel_addr;
                            BUS_WE   <= sel_we;
                            state    <= sel_we ? WR : RD_ADDR;
                        end
                    end
                end
                // A write completes through RD_ACK as well: it is simply the owner's ACK cycle.
                WR: begin
                    BUS_WE <= 1'b0;
                    ACK    <= GNT;
                    state  <= RD_ACK;
                end
                RD_ADDR: begin
                    state <= RD_DATA;
                end
                RD_DATA: begin
                    RDATA <= BUS_DATA;
                    ACK   <= GNT;
                    state <= RD_ACK;
                end
                RD_ACK, ERR: begin
                    GNT   <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Bench for ram_bus_arbiter: a behavioural RAM on the bus, per-requester request queues,
// a transaction-level reference model feeding an expected-completion queue.
module tb_ram_bus_arbiter;
    import ram_bus_pkg::*;

    localparam logic [7:0] BASE = 8'h00;
    localparam int         AW   = 7;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [1:0]  REQ, WE;
    logic [7:0]  ADDR0, ADDR1, WDATA0, WDATA1;
    logic [1:0]  GNT, ACK;
    logic [7:0]  RDATA, BUS_ADDR;
    wire  [7:0]  BUS_DATA;
    logic        BUS_WE;
    state_t      DBG_STATE;

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    ram_bus_arbiter #(.RAMBaseAddr(BASE), .RAMAddrWidth(AW)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .WE(WE),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .GNT(GNT), .ACK(ACK), .RDATA(RDATA), .BUS_ADDR(BUS_ADDR),
        .BUS_DATA(BUS_DATA), .BUS_WE(BUS_WE), .DBG_STATE(DBG_STATE)
    );

    // ---------------- bus RAM (sync read, data one cycle after address) ----------------
    logic [7:0] ram [256];
    logic [7:0] ram_q;
    logic       ld_en;
    logic [7:0] ld_addr, ld_data;

    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (BUS_DATA[g]);
    end

    always @(posedge CLK) begin
        if (ld_en) ram[ld_addr] <= ld_data;
        else if (BUS_WE === 1'b1) ram[BUS_ADDR] <= BUS_DATA;
        ram_q <= ram[BUS_ADDR];
    end
    assign BUS_DATA = (DBG_STATE == RD_DATA) ? ram_q : 8'hzz;

    // ---------------- types, queues, counters ----------------
    typedef struct packed { logic we; logic [7:0] addr; logic [7:0] wdata; } txn_t;
    typedef struct packed {
        logic owner; logic we; logic hit;
        logic [7:0] addr; logic [7:0] wdata; logic [7:0] rdata; logic [7:0] done;
    } exp_t;
    localparam int W = $bits(exp_t);

    typedef struct {
        int id; logic we; logic [7:0] addr; logic [7:0] wdata;
        int lat; logic [7:0] rdata; logic bus_wr;
    } vec_t;

    logic [W-1:0] exp_q[$];
    txn_t         q0[$], q1[$];
    int           ack_hist[$];
    int           checks = 0;
    int           failures = 0;
    int           rc, bw_cnt;
    logic [7:0]   bw_addr, bw_data;

    // reference model state
    logic [7:0]   mem_m [256];
    logic         last_m;
    logic [7:0]   rdata_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic hit_of(input logic [7:0] a);
        return (int'(a) >= int'(BASE)) && (int'(a) < int'(BASE) + (1 << AW));
    endfunction

    function automatic int lat_of(input txn_t t);
        if (!hit_of(t.addr)) return 2;
        return t.we ? 3 : 4;
    endfunction

    task automatic model_serve(input int owner, input txn_t t, input int done, input bit push);
        exp_t e;
        logic h;
        h = hit_of(t.addr);
        if (t.we && h) mem_m[t.addr] = t.wdata;
        if (!t.we) rdata_m = h ? mem_m[t.addr] : 8'h00;
        e.owner = owner[0]; e.we = t.we; e.hit = h; e.addr = t.addr;
        e.wdata = t.wdata;  e.rdata = rdata_m; e.done = 8'(done);
        if (push) exp_q.push_back(W'(e));
    endtask

    // Service order: a lone pending requester goes next; with both pending the one not served last goes.
    task automatic model_round();
        txn_t m0[$], m1[$];
        txn_t t;
        int   w, cyc;
        m0 = q0; m1 = q1; cyc = 0;
        while (m0.size() != 0 || m1.size() != 0) begin
            if (m0.size() != 0 && m1.size() != 0) w = (last_m == 1'b1) ? 0 : 1;
            else w = (m0.size() != 0) ? 0 : 1;
            t = (w == 0) ? m0.pop_front() : m1.pop_front();
            cyc += lat_of(t);
            model_serve(w, t, cyc, 1'b1);
            last_m = w[0];
        end
    endtask

    // ---------------- driver ----------------
    task automatic push_txn(input int id, input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        txn_t t;
        t = '{we: we, addr: addr, wdata: wdata};
        if (id == 0) q0.push_back(t); else q1.push_back(t);
    endtask

    task automatic drive();
        REQ[0] = (q0.size() != 0);
        REQ[1] = (q1.size() != 0);
        if (q0.size() != 0) begin WE[0] = q0[0].we; ADDR0 = q0[0].addr; WDATA0 = q0[0].wdata; end
        if (q1.size() != 0) begin WE[1] = q1[0].we; ADDR1 = q1[0].addr; WDATA1 = q1[0].wdata; end
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic monitor();
        exp_t e;
        check("gnt_onehot0", 32'($onehot0(GNT)), 32'd1);
        if (BUS_WE === 1'b1) begin
            bw_cnt++; bw_addr = BUS_ADDR; bw_data = BUS_DATA;
        end else if (DBG_STATE != RD_DATA) begin
            check("bus_released", 32'(BUS_DATA), 32'hFF);
        end
        if (ACK !== 2'b00) begin
            ack_hist.push_back(ACK[1] ? 1 : 0);
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_ack: ACK=%b with nothing outstanding (t=%0t)", ACK, $time);
            end else begin
                e = exp_t'(exp_q.pop_front());
                check("ack_owner",  32'(ACK), 32'(2'b01 << e.owner));
                check("ack_cycle",  32'(rc), 32'(e.done));
                check("gnt_in_ack", 32'(GNT), 32'(ACK));
                check("rdata",      32'(RDATA), 32'(e.rdata));
                check("bus_writes", 32'(bw_cnt), (e.we && e.hit) ? 32'd1 : 32'd0);
                if (e.we && e.hit) begin
                    check("bus_wr_addr", 32'(bw_addr), 32'(e.addr));
                    check("bus_wr_data", 32'(bw_data), 32'(e.wdata));
                end
            end
            bw_cnt = 0;
            if (ACK[0] && q0.size() != 0) void'(q0.pop_front());
            if (ACK[1] && q1.size() != 0) void'(q1.pop_front());
        end
    endtask

    task automatic step();
        @(negedge CLK);
        rc++;
        monitor();
        drive();
    endtask

    task automatic run_round(input bit use_model, input int budget);
        int n;
        if (use_model) model_round();
        bw_cnt = 0;
        @(negedge CLK);
        drive();
        rc = 1;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check("round_done", 32'(n < budget), 32'd1);
        if (n >= budget) begin
            q0.delete(); q1.delete(); drive();
        end
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        step();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_gnt"},      32'(GNT), 32'd0);
        check({tag, "_ack"},      32'(ACK), 32'd0);
        check({tag, "_rdata"},    32'(RDATA), 32'd0);
        check({tag, "_bus_addr"}, 32'(BUS_ADDR), 32'd0);
        check({tag, "_bus_we"},   32'(BUS_WE), 32'd0);
        check({tag, "_bus_data"}, 32'(BUS_DATA), 32'hFF);
        check({tag, "_state"},    32'(DBG_STATE), 32'(IDLE));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        vec_t   vecs[9];
        exp_t   e;
        txn_t   t;
        int     mask, n, sel;
        logic [7:0] v;

        vecs[0] = '{0, 1'b1, 8'h10, 8'hA5, 3, 8'h00, 1'b1};
        vecs[1] = '{1, 1'b0, 8'h10, 8'h00, 4, 8'hA5, 1'b0};
        vecs[2] = '{0, 1'b0, 8'h80, 8'h00, 2, 8'h00, 1'b0};
        vecs[3] = '{1, 1'b1, 8'h7F, 8'h3C, 3, 8'h00, 1'b1};
        vecs[4] = '{0, 1'b0, 8'h7F, 8'h00, 4, 8'h3C, 1'b0};
        vecs[5] = '{1, 1'b1, 8'hFF, 8'h11, 2, 8'h3C, 1'b0};
        vecs[6] = '{1, 1'b1, 8'h00, 8'h5A, 3, 8'h3C, 1'b1};
        vecs[7] = '{0, 1'b0, 8'h00, 8'h00, 4, 8'h5A, 1'b0};
        vecs[8] = '{1, 1'b0, 8'h81, 8'h00, 2, 8'h00, 1'b0};

        RESET = 1'b1; REQ = 2'b00; WE = 2'b00;
        ADDR0 = 8'h00; ADDR1 = 8'h00; WDATA0 = 8'h00; WDATA1 = 8'h00;
        ld_en = 1'b1; ld_addr = 8'h00; ld_data = 8'h00;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            ld_addr = 8'(i); ld_data = v; mem_m[i] = v;
            @(negedge CLK);
        end
        ld_en = 1'b0;
        check_reset_state("reset");
        RESET = 1'b0;
        last_m = 1'b1; rdata_m = 8'h00; rc = 0; bw_cnt = 0;

        // table-driven single transactions with constant expectations
        for (int i = 0; i < 9; i++) begin
            push_txn(vecs[i].id, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            t = '{we: vecs[i].we, addr: vecs[i].addr, wdata: vecs[i].wdata};
            model_serve(vecs[i].id, t, 0, 1'b0);
            last_m = vecs[i].id[0];
            e.owner = vecs[i].id[0]; e.we = vecs[i].we; e.hit = vecs[i].bus_wr;
            e.addr = vecs[i].addr; e.wdata = vecs[i].wdata;
            e.rdata = vecs[i].rdata; e.done = 8'(vecs[i].lat);
            exp_q.push_back(W'(e));
            run_round(1'b0, 20);
        end

        // contention: both hold REQ across two reads each -> strict alternation 0,1,0,1
        ack_hist.delete();
        push_txn(0, 1'b0, 8'h10, 8'h00); push_txn(0, 1'b0, 8'h7F, 8'h00);
        push_txn(1, 1'b0, 8'h00, 8'h00); push_txn(1, 1'b0, 8'h10, 8'h00);
        run_round(1'b1, 40);
        check("alt_count", 32'(ack_hist.size()), 32'd4);
        if (ack_hist.size() == 4) begin
            for (int i = 0; i < 4; i++) check("alt_order", 32'(ack_hist[i]), 32'(i % 2));
        end

        // reset while a read sits in RD_DATA: aborted, nothing acknowledged afterwards
        push_txn(0, 1'b0, 8'h10, 8'h00);
        bw_cnt = 0;
        @(negedge CLK); drive(); rc = 1;
        step(); step();
        check("pre_reset_state", 32'(DBG_STATE), 32'(RD_DATA));
        RESET = 1'b1;
        @(negedge CLK);
        check_reset_state("midreset");
        q0.delete(); drive();
        RESET = 1'b0;
        last_m = 1'b1; rdata_m = 8'h00;
        for (int i = 0; i < 4; i++) step();
        push_txn(1, 1'b1, 8'h20, 8'h77); push_txn(0, 1'b0, 8'h20, 8'h00);
        run_round(1'b1, 30);
        push_txn(1, 1'b0, 8'h20, 8'h00);
        run_round(1'b1, 20);

        // randomized rounds against the model
        for (int r = 0; r < 80; r++) begin
            mask = $urandom_range(1, 3);
            for (int id = 0; id < 2; id++) begin
                if (mask[id]) begin
                    n = $urandom_range(1, 3);
                    for (int k = 0; k < n; k++) begin
                        sel = $urandom_range(0, 9);
                        if (sel == 0)      v = 8'h7F;
                        else if (sel == 1) v = 8'h80;
                        else if (sel <= 3) v = 8'(8'h80 + $urandom_range(0, 127));
                        else               v = 8'($urandom_range(0, 127));
                        push_txn(id, 1'($urandom_range(0, 1)), v, 8'($urandom));
                    end
                end
            end
            run_round(1'b1, 60);
            n = $urandom_range(0, 2);
            for (int k = 0; k < n; k++) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
